// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the KS10 backplane bus arbiter.
package bus_arb_pkg;

    // Arbiter FSM states; IDLE must stay the all-zero encoding so reset lands there.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    // Width of one KS10 word (address+flags or data).
    localparam int WORD = 36;

    // Largest supported master count and the index width that covers it.
    localparam int MAXREQ = 8;
    localparam int IDXW   = 3;

    // Expand a master index into a one-hot vector; callers truncate to NREQ bits.
    function automatic logic [MAXREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [MAXREQ-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index wins) or
// round-robin starting one past the last owner, with wrap-around.
module bus_arb_pick #(
    parameter int NREQ   = 4,
    parameter int IW     = 2,
    parameter int RROBIN = 0
) (
    input  logic [NREQ-1:0] reqI,
    input  logic [IW-1:0]   lastI,
    output logic [IW-1:0]   winnerO,
    output logic            validO
);

    // Walk the candidates in priority order and keep the first requester found.
    always_comb begin : pickSearch
        int cand;
        cand    = 0;
        winnerO = '0;
        validO  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (RROBIN != 0) begin
                cand = (int'(lastI) + 1 + i) % NREQ;
            end else begin
                cand = i;
            end
            if (!validO && reqI[IW'(cand)]) begin
                validO  = 1'b1;
                winnerO = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// KS10 backplane bus arbiter: grants one master at a time, forwards its
// address/data to the bus, waits for the slave acknowledge (or a watchdog
// expiry) and returns a completion pulse to the owner.
//
// Handshake: a master raises reqI[m] and holds it, with addrI/dataI slice m
// stable, until it sees a one-cycle ackO[m]. The word is captured at grant,
// so the master may change its slices once gntO[m] is high. nxmO[m] only
// ever accompanies ackO[m] and marks a cycle that no slave answered.
// On the bus side busREQO is held for the whole transaction and the first
// busACKI seen during BUSY completes it; busACKI outside BUSY is ignored.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 127,
    parameter int RROBIN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      reqI,
    input  logic [NREQ*WORD-1:0] addrI,
    input  logic [NREQ*WORD-1:0] dataI,
    output logic [NREQ-1:0]      ackO,
    output logic [NREQ-1:0]      nxmO,
    output logic [NREQ-1:0]      gntO,
    output logic                 busREQO,
    output logic [WORD-1:0]      busADDRO,
    output logic [WORD-1:0]      busDATAO,
    input  logic                 busACKI,
    output logic                 busyO,
    output arbState_t            stateO
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    arbState_t       state;
    arbState_t       nextState;
    logic [IW-1:0]   pickIdx;
    logic            pickValid;
    logic [IW-1:0]   ownerIdx;
    logic [IW-1:0]   lastOwner;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] pickOh;
    logic [NREQ-1:0] ownerOh;
    logic            timerDone;

    // Priority / wrap-around search lives in its own block so it can be
    // exercised on its own.
    bus_arb_pick #(
        .NREQ   (NREQ),
        .IW     (IW),
        .RROBIN (RROBIN)
    ) uPick (
        .reqI    (reqI),
        .lastI   (lastOwner),
        .winnerO (pickIdx),
        .validO  (pickValid)
    );

    assign pickOh    = NREQ'(onehot(IDXW'(pickIdx)));
    assign ownerOh   = NREQ'(onehot(IDXW'(ownerIdx)));
    assign timerDone = (timer == '0);
    assign stateO    = state;

    // State register; reset abandons any cycle in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode: ack beats watchdog expiry, RELEASE lasts one cycle.
    always_comb begin
        nextState = state;
        busyO     = (state != IDLE);
        case (state)
            IDLE: begin
                if (pickValid) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (busACKI || timerDone) begin
                    nextState = RELEASE;
                end
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Grant, bus word latches, watchdog timer and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gntO      <= '0;
            ackO      <= '0;
            nxmO      <= '0;
            busREQO   <= 1'b0;
            busADDRO  <= '0;
            busDATAO  <= '0;
            timer     <= '0;
            ownerIdx  <= '0;
            lastOwner <= IW'(NREQ - 1);
        end else begin
            ackO <= '0;
            nxmO <= '0;
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        gntO     <= pickOh;
                        ownerIdx <= pickIdx;
                        busADDRO <= addrI[WORD*pickIdx +: WORD];
                        busDATAO <= dataI[WORD*pickIdx +: WORD];
                        busREQO  <= 1'b1;
                        timer    <= TW'(TIMEOUT);
                    end
                end
                BUSY: begin
                    if (busACKI) begin
                        ackO    <= ownerOh;
                        gntO    <= '0;
                        busREQO <= 1'b0;
                    end else if (timerDone) begin
                        ackO    <= ownerOh;
                        nxmO    <= ownerOh;
                        gntO    <= '0;
                        busREQO <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RELEASE: begin
                    lastOwner <= ownerIdx;
                end
                default: begin
                    gntO    <= '0;
                    busREQO <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: a fixed-priority and a round-robin instance share the
// same stimulus; each has its own expected grant and completion queues that
// a negedge monitor pops whenever the instance shows a grant or a pulse.
module tb_bus_arb;
    import bus_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      reqI;
    logic [NREQ*WORD-1:0] addrI;
    logic [NREQ*WORD-1:0] dataI;
    logic                 busACKI;

    logic [NREQ-1:0] ackF, nxmF, gntF, ackR, nxmR, gntR;
    logic            busReqF, busReqR, busyF, busyR;
    logic [WORD-1:0] addrOF, dataOF, addrOR, dataOR;
    arbState_t       stateF, stateR;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // grant record: {cycle[15:0], gnt[3:0], addr[35:0], data[35:0]}
    logic [91:0] expGntF[$];
    logic [91:0] expGntR[$];
    // completion record: {cycle[15:0], ack[3:0], nxm[3:0]}
    logic [23:0] expCmpF[$];
    logic [23:0] expCmpR[$];

    logic [3:0] prevGF = '0;
    logic [3:0] prevGR = '0;

    bus_arb #(.NREQ(NREQ), .TIMEOUT(TMO), .RROBIN(0)) uFix (
        .clk(clk), .rst(rst), .reqI(reqI), .addrI(addrI), .dataI(dataI),
        .ackO(ackF), .nxmO(nxmF), .gntO(gntF), .busREQO(busReqF),
        .busADDRO(addrOF), .busDATAO(dataOF), .busACKI(busACKI),
        .busyO(busyF), .stateO(stateF)
    );

    bus_arb #(.NREQ(NREQ), .TIMEOUT(TMO), .RROBIN(1)) uRr (
        .clk(clk), .rst(rst), .reqI(reqI), .addrI(addrI), .dataI(dataI),
        .ackO(ackR), .nxmO(nxmR), .gntO(gntR), .busREQO(busReqR),
        .busADDRO(addrOR), .busDATAO(dataOR), .busACKI(busACKI),
        .busyO(busyR), .stateO(stateR)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // d: 0 = fixed instance, 1 = round-robin instance, 2 = both
    task automatic pushGnt(input int d, input int c, input int port);
        logic [91:0] rec;
        logic [3:0]  oh;
        oh  = 4'b0001 << port;
        rec = {16'(c), oh, addrI[36*port +: 36], dataI[36*port +: 36]};
        if (d != 1) expGntF.push_back(rec);
        if (d != 0) expGntR.push_back(rec);
    endtask

    task automatic pushCmp(input int d, input int c, input int port, input bit nxm);
        logic [23:0] rec;
        logic [3:0]  oh;
        oh  = 4'b0001 << port;
        rec = {16'(c), oh, (nxm ? oh : 4'b0000)};
        if (d != 1) expCmpF.push_back(rec);
        if (d != 0) expCmpR.push_back(rec);
    endtask

    task automatic monStep(input int d, input logic [3:0] gnt, input logic [3:0] prevG,
                           input logic [3:0] ack, input logic [3:0] nxm,
                           input logic busReq, input logic busy,
                           input logic [35:0] a, input logic [35:0] dt);
        logic [91:0] eg;
        logic [23:0] ec;
        bit ok;
        check($sformatf("busreq_tracks_gnt_d%0d", d), {127'd0, busReq}, {127'd0, |gnt});
        if (gnt != '0 && prevG == '0) begin
            ok = 1'b0;
            eg = '0;
            if (d == 0 && expGntF.size() > 0) begin eg = expGntF.pop_front(); ok = 1'b1; end
            if (d == 1 && expGntR.size() > 0) begin eg = expGntR.pop_front(); ok = 1'b1; end
            if (!ok) begin
                check($sformatf("unexpected_grant_d%0d", d), {124'd0, gnt}, 128'd0);
            end else begin
                check($sformatf("grant_d%0d", d), {36'd0, 16'(cyc), gnt, a, dt}, {36'd0, eg});
                check($sformatf("busy_at_grant_d%0d", d), {127'd0, busy}, 128'd1);
            end
        end
        if (ack != '0 || nxm != '0) begin
            ok = 1'b0;
            ec = '0;
            if (d == 0 && expCmpF.size() > 0) begin ec = expCmpF.pop_front(); ok = 1'b1; end
            if (d == 1 && expCmpR.size() > 0) begin ec = expCmpR.pop_front(); ok = 1'b1; end
            if (!ok) begin
                check($sformatf("unexpected_ack_d%0d", d), {120'd0, ack, nxm}, 128'd0);
            end else begin
                check($sformatf("completion_d%0d", d), {104'd0, 16'(cyc), ack, nxm}, {104'd0, ec});
                check($sformatf("busy_in_release_d%0d", d), {127'd0, busy}, 128'd1);
            end
        end
    endtask

    // monitor: sample away from the active edge
    always @(negedge clk) begin
        monStep(0, gntF, prevGF, ackF, nxmF, busReqF, busyF, addrOF, dataOF);
        monStep(1, gntR, prevGR, ackR, nxmR, busReqR, busyR, addrOR, dataOR);
        prevGF = gntF;
        prevGR = gntR;
    end

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // driver / directed scenarios
    initial begin : stim
        int n;
        int m;
        int k;
        rst = 1'b1; reqI = '0; addrI = '0; dataI = '0; busACKI = 1'b0;
        #1;
        check("reset_out_fix", {42'd0, ackF, nxmF, gntF, busReqF, addrOF, dataOF, busyF}, 128'd0);
        check("reset_out_rr",  {42'd0, ackR, nxmR, gntR, busReqR, addrOR, dataOR, busyR}, 128'd0);
        tick(2);
        rst = 1'b0;

        // single request, ack three cycles after grant
        tick(1);
        n = cyc;
        addrI[35:0] = 36'o000000001000;
        dataI[35:0] = 36'o123456701234;
        reqI = 4'b0001;
        pushGnt(2, n + 1, 0);
        tick(3);
        busACKI = 1'b1;
        pushCmp(2, n + 4, 0, 1'b0);
        tick(1);
        busACKI = 1'b0;
        reqI = 4'b0000;
        tick(3);

        // simultaneous requests 1 and 3, immediate ack
        doReset();
        n = cyc;
        addrI[36*1 +: 36] = 36'o000000002001; dataI[36*1 +: 36] = 36'o111111111111;
        addrI[36*3 +: 36] = 36'o400000003003; dataI[36*3 +: 36] = 36'o333333333333;
        reqI = 4'b1010;
        busACKI = 1'b1;
        pushGnt(2, n + 1, 1); pushCmp(2, n + 2, 1, 1'b0);
        pushGnt(2, n + 4, 3); pushCmp(2, n + 5, 3, 1'b0);
        tick(2);
        reqI = 4'b1000;
        tick(3);
        reqI = 4'b0000;
        busACKI = 1'b0;
        tick(3);

        // all four continuously, ack held high (stale in IDLE/RELEASE)
        doReset();
        n = cyc;
        for (int p = 0; p < NREQ; p++) begin
            addrI[36*p +: 36] = 36'(64'o000000010000 + p);
            dataI[36*p +: 36] = 36'(64'o000000770000 + p);
        end
        reqI = 4'b1111;
        busACKI = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pushGnt(0, n + 1 + 3*i, 0);     pushCmp(0, n + 2 + 3*i, 0, 1'b0);
            pushGnt(1, n + 1 + 3*i, i % 4); pushCmp(1, n + 2 + 3*i, i % 4, 1'b0);
        end
        tick(14);
        reqI = 4'b0000;
        busACKI = 1'b0;
        tick(3);

        // watchdog expiry, then ack on the expiry cycle
        doReset();
        n = cyc;
        addrI[36*2 +: 36] = 36'o777777000002;
        dataI[36*2 +: 36] = 36'o000000555555;
        reqI = 4'b0100;
        pushGnt(2, n + 1, 2);
        pushCmp(2, n + 1 + TMO + 1, 2, 1'b1);
        tick(7);
        reqI = 4'b0000;
        tick(2);
        m = cyc;
        reqI = 4'b0100;
        pushGnt(2, m + 1, 2);
        pushCmp(2, m + 7, 2, 1'b0);
        tick(6);
        busACKI = 1'b1;
        tick(1);
        busACKI = 1'b0;
        reqI = 4'b0000;
        tick(3);

        // reset two cycles after grant, then a pending request on port 2
        doReset();
        n = cyc;
        addrI[35:0] = 36'o000000004444;
        reqI = 4'b0001;
        pushGnt(2, n + 1, 0);
        tick(3);
        rst = 1'b1;
        reqI = 4'b0100;
        #1;
        check("async_reset_fix", {42'd0, ackF, nxmF, gntF, busReqF, addrOF, dataOF, busyF}, 128'd0);
        check("async_reset_rr",  {42'd0, ackR, nxmR, gntR, busReqR, addrOR, dataOR, busyR}, 128'd0);
        check("async_reset_state", {124'd0, stateF, stateR}, 128'd0);
        tick(2);
        rst = 1'b0;
        k = cyc;
        busACKI = 1'b1;
        pushGnt(2, k + 1, 2);
        pushCmp(2, k + 2, 2, 1'b0);
        tick(2);
        reqI = 4'b0000;
        busACKI = 1'b0;
        tick(3);

        check("leftover_expected",
              128'(expGntF.size() + expGntR.size() + expCmpF.size() + expCmpR.size()), 128'd0);
        summary();
        $finish;
    end

    // time bound in case the scenario flow ever stalls
    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected scenario end (cycle %0d)", cyc);
        summary();
        $finish;
    end

endmodule
